// File: rtl/dadda_vec_sequencer_if.sv
// Bus bundle between the Dadda vector sequencer and its operand ROM, multiplier and result RAM.
// master = sequencer side, slave = environment (ROM/multiplier/RAM/controller) side.
interface dadda_vec_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   num_vec;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [31:0]       rom_dout;
    logic [15:0]       mul_a;
    logic [15:0]       mul_b;
    logic [31:0]       mul_p;
    logic [ADDR_W-1:0] res_addr;
    logic              res_we;
    logic [31:0]       res_din;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_cnt;

    modport master (
        input  start, abort, num_vec, rom_dout, mul_p,
        output rom_addr, rom_en, mul_a, mul_b, res_addr, res_we, res_din,
               busy, done, err_cnt
    );

    modport slave (
        output start, abort, num_vec, rom_dout, mul_p,
        input  rom_addr, rom_en, mul_a, mul_b, res_addr, res_we, res_din,
               busy, done, err_cnt
    );
endinterface

// File: rtl/dadda_vec_sequencer.sv
// Streams a batch of operand words through the 16x16 multiplier into the result RAM.
// Optional feature macro: DADDA_SELFCHECK_EN (behavioural product check counted in err_cnt).
module dadda_vec_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int ROM_LAT = 1,
    parameter int MUL_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dadda_vec_sequencer_if.master  bus
);
    localparam int CNT_MAX = (ROM_LAT > MUL_LAT + 1) ? ROM_LAT : MUL_LAT + 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MUL,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W:0]   r_num_vec;
    logic [ADDR_W:0]   r_idx;
    logic [15:0]       r_mul_a;
    logic [15:0]       r_mul_b;
    logic [31:0]       r_res_din;

    logic w_accept;
    logic w_rd_last;
    logic w_mul_last;
    logic w_last_vec;
    logic w_advance;
    logic w_load_ops;
    logic w_load_res;

    assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_rd_last  = (r_cnt == RD_LAST);
    assign w_mul_last = (r_cnt == MUL_LAST);
    // Compare at ADDR_W+1 bits so a full-range batch does not wrap early.
    assign w_last_vec = (r_idx == (r_num_vec - (ADDR_W+1)'(1)));

    assign w_advance  = (r_state == S_WR)  && (w_state_next == S_RD);
    assign w_load_ops = (r_state == S_RD)  && (w_state_next == S_MUL);
    assign w_load_res = (r_state == S_MUL) && (w_state_next == S_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.num_vec == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (w_rd_last) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                w_state_next = w_last_vec ? S_DONE : S_RD;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Abort overrides every transition; a write already on the bus this cycle still lands.
        if (bus.abort) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_num_vec <= '0;
            r_idx     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_res_din <= '0;
        end else begin
            if (r_state != w_state_next) begin
                r_cnt <= '0;
            end else if ((r_state == S_RD) || (r_state == S_MUL)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_num_vec <= bus.num_vec;
                r_idx     <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + (ADDR_W+1)'(1);
            end

            if (w_load_ops) begin
                r_mul_a <= bus.rom_dout[15:0];
                r_mul_b <= bus.rom_dout[31:16];
            end

            if (w_load_res) begin
                r_res_din <= bus.mul_p;
            end
        end
    end

    assign bus.rom_en   = (r_state == S_RD);
    assign bus.rom_addr = r_idx[ADDR_W-1:0];
    assign bus.mul_a    = r_mul_a;
    assign bus.mul_b    = r_mul_b;
    assign bus.res_we   = (r_state == S_WR);
    assign bus.res_addr = r_idx[ADDR_W-1:0];
    assign bus.res_din  = r_res_din;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);

`ifdef DADDA_SELFCHECK_EN
    logic [31:0]     w_ref_p;
    logic [ADDR_W:0] r_err_cnt;

    assign w_ref_p = {16'h0000, r_mul_a} * {16'h0000, r_mul_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
        end else if ((r_state == S_WR) && (r_res_din != w_ref_p) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_dadda_vec_sequencer.sv
// Directed bench for dadda_vec_sequencer: batch table plus reset, abort and MUL_LAT=2 sequences.
module tb_dadda_vec_sequencer;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dadda_vec_sequencer_if #(.ADDR_W(ADDR_W)) bus0 ();
    dadda_vec_sequencer_if #(.ADDR_W(ADDR_W)) bus1 ();

    dadda_vec_sequencer #(.ADDR_W(ADDR_W), .ROM_LAT(1), .MUL_LAT(0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    dadda_vec_sequencer #(.ADDR_W(ADDR_W), .ROM_LAT(1), .MUL_LAT(2)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    logic [31:0] rom [8];

    assign bus0.rom_dout = bus0.rom_en ? rom[bus0.rom_addr] : 32'h0;
    assign bus1.rom_dout = bus1.rom_en ? rom[bus1.rom_addr] : 32'h0;
    assign bus0.mul_p    = {16'h0, bus0.mul_a} * {16'h0, bus0.mul_b};

    // Two-stage multiplier stub that is off by one for operands a=4, b=5.
    logic [31:0] stub_p1, stub_p2;
    always @(posedge clk) begin
        stub_p1 <= {16'h0, bus1.mul_a} * {16'h0, bus1.mul_b}
                   + (((bus1.mul_a == 16'd4) && (bus1.mul_b == 16'd5)) ? 32'd1 : 32'd0);
        stub_p2 <= stub_p1;
    end
    assign bus1.mul_p = stub_p2;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int nvec;
        int done_cyc;
        int start_pulse_cyc;
        int abort_cyc;
        int exp_writes;
        int exp_done_pulses;
        int exp_busy_last;
        int exp_rd;
    } batch_t;

    batch_t      tab [5];
    logic [31:0] exp_p [8];

    int          wr_n, rd_n, done_n, done_at, busy_last;
    int          wr_cyc [16];
    logic [2:0]  wr_addr [16];
    logic [31:0] wr_din [16];
    logic [3:0]  err_at_done;

    task automatic run_batch(input batch_t b);
        wr_n = 0; rd_n = 0; done_n = 0; done_at = -1; busy_last = 0;
        @(negedge clk);
        bus0.num_vec = 4'(b.nvec);
        bus0.start   = 1'b1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            if (bus0.res_we) begin
                if (wr_n < 16) begin
                    wr_cyc[wr_n]  = cyc;
                    wr_addr[wr_n] = bus0.res_addr;
                    wr_din[wr_n]  = bus0.res_din;
                end
                wr_n++;
            end
            if (bus0.rom_en) rd_n++;
            if (bus0.done) begin
                done_n++;
                done_at = cyc;
            end
            if (bus0.busy) busy_last = cyc;
            bus0.start = (cyc == b.start_pulse_cyc);
            bus0.abort = (cyc == b.abort_cyc);
        end
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " rom_en"},   64'(bus0.rom_en),   64'h0);
        chk({tag, " rom_addr"}, 64'(bus0.rom_addr), 64'h0);
        chk({tag, " mul_a"},    64'(bus0.mul_a),    64'h0);
        chk({tag, " mul_b"},    64'(bus0.mul_b),    64'h0);
        chk({tag, " res_we"},   64'(bus0.res_we),   64'h0);
        chk({tag, " res_addr"}, 64'(bus0.res_addr), 64'h0);
        chk({tag, " res_din"},  64'(bus0.res_din),  64'h0);
        chk({tag, " busy"},     64'(bus0.busy),     64'h0);
        chk({tag, " done"},     64'(bus0.done),     64'h0);
        chk({tag, " err_cnt"},  64'(bus0.err_cnt),  64'h0);
    endtask

    initial begin
        int we_seen;
        int exp_err;

        for (int i = 0; i < 7; i++) rom[i] = {16'(i + 2), 16'(i + 1)};
        rom[7] = 32'hFFFF_FFFF;
        exp_p = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'hFFFE_0001};

        //         nvec done startp abort writes dones busylast rd
        tab[0] = '{6,   19,  0,     0,    6,     1,    19,      6};
        tab[1] = '{0,   1,   0,     0,    0,     1,    1,       0};
        tab[2] = '{8,   25,  0,     0,    8,     1,    25,      8};
        tab[3] = '{1,   4,   4,     0,    1,     1,    4,       1};
        tab[4] = '{6,   -1,  4,     8,    2,     0,    8,       3};

        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.num_vec = '0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.num_vec = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Asynchronous reset while vector 0 sits in MUL.
        @(negedge clk);
        bus0.num_vec = 4'd6;
        bus0.start   = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        chk("pre_reset mul_a", 64'(bus0.mul_a), 64'd1);
        chk("pre_reset busy",  64'(bus0.busy),  64'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.res_we) we_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.res_we) we_seen++;
        end
        chk("post_reset res_we count", 64'(we_seen), 64'd0);

        for (int t = 0; t < 5; t++) begin
            run_batch(tab[t]);
            $display("batch %0d nvec=%0d writes=%0d reads=%0d done_at=%0d busy_last=%0d",
                     t, tab[t].nvec, wr_n, rd_n, done_at, busy_last);
            chk($sformatf("b%0d writes", t),    64'(wr_n),      64'(tab[t].exp_writes));
            chk($sformatf("b%0d reads", t),     64'(rd_n),      64'(tab[t].exp_rd));
            chk($sformatf("b%0d done_n", t),    64'(done_n),    64'(tab[t].exp_done_pulses));
            chk($sformatf("b%0d done_at", t),   64'(done_at),   64'(tab[t].done_cyc));
            chk($sformatf("b%0d busy_last", t), 64'(busy_last), 64'(tab[t].exp_busy_last));
            for (int i = 0; i < tab[t].exp_writes && i < wr_n; i++) begin
                chk($sformatf("b%0d w%0d addr", t, i), 64'(wr_addr[i]), 64'(i));
                chk($sformatf("b%0d w%0d din", t, i),  64'(wr_din[i]),  64'(exp_p[i]));
                chk($sformatf("b%0d w%0d cyc", t, i),  64'(wr_cyc[i]),  64'(3 * (i + 1)));
            end
        end

        // MUL_LAT=2 instance with the faulty stub on vector 3.
`ifdef DADDA_SELFCHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        wr_n = 0; done_n = 0; done_at = -1; err_at_done = '0;
        @(negedge clk);
        bus1.num_vec = 4'd5;
        bus1.start   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.res_we) begin
                if (wr_n < 16) begin
                    wr_cyc[wr_n]  = cyc;
                    wr_addr[wr_n] = bus1.res_addr;
                    wr_din[wr_n]  = bus1.res_din;
                end
                wr_n++;
            end
            if (bus1.done) begin
                done_n++;
                done_at     = cyc;
                err_at_done = bus1.err_cnt;
            end
        end
        $display("mul_lat2 writes=%0d done_at=%0d err_cnt=%0d", wr_n, done_at, err_at_done);
        chk("ml2 writes",  64'(wr_n),        64'd5);
        chk("ml2 done_n",  64'(done_n),      64'd1);
        chk("ml2 done_at", 64'(done_at),     64'd26);
        chk("ml2 err_cnt", 64'(err_at_done), 64'(exp_err));
        for (int i = 0; i < 5 && i < wr_n; i++) begin
            chk($sformatf("ml2 w%0d addr", i), 64'(wr_addr[i]), 64'(i));
            chk($sformatf("ml2 w%0d cyc", i),  64'(wr_cyc[i]),  64'(5 * (i + 1)));
            chk($sformatf("ml2 w%0d din", i),  64'(wr_din[i]),
                64'((i == 3) ? 32'd21 : exp_p[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
